seq_det_prog_moore: RTL and testbench

Programmable-pattern Moore sequence detector for serial bit streams. It replaces fixed-pattern detectors with a single block: a run-time loadable pattern of 1..MAX_LEN bits, an overlap/non-overlap mode, an input-valid qualifier and a saturating match counter. It sits on a serial input path and drives a registered one-cycle match flag plus a statistics count to downstream control logic.

---
 rtl/seq_det_pkg.sv | 10 +
 rtl/seq_det_sat_cnt.sv | 14 +
 rtl/seq_det_prog_moore.sv | 73 +++++++
 tb/tb_seq_det_prog_moore.sv | 128 ++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: state encoding and width helper for the programmable sequence detector
package seq_det_pkg;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] FILL = 2'b01;
  localparam logic [1:0] HUNT = 2'b10;
  localparam logic [1:0] HIT  = 2'b11;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: saturating counter, clear dominates increment
module seq_det_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/seq_det_prog_moore.sv
// seq_det_prog_moore: run-time programmable Moore pattern detector with overlap mode and hit counter
module seq_det_prog_moore
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);
  logic [MAX_LEN-1:0] pat, hist, hist_n, mask;
  logic [LEN_W-1:0]   len, fill, nfill, fill_n;
  logic [1:0]         state, state_n;
  logic               ovl, step, hit, cfg_ok;
  always_comb begin
    cfg_ok  = cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN);
    step    = en && !cfg_load && state != IDLE;
    hist_n  = {hist[MAX_LEN-2:0], x};
    mask    = ~({MAX_LEN{1'b1}} << len);
    nfill   = fill == len ? len : fill + 1'b1;
    hit     = step && nfill == len && ((hist_n ^ pat) & mask) == '0;
    fill_n  = hit ? (ovl ? len : '0) : nfill;
    state_n = step ? (hit ? HIT : nfill == len ? HUNT : FILL)
            : state == HIT ? (ovl ? HUNT : FILL) : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pat     <= '0;
      len     <= '0;
      ovl     <= 1'b0;
      hist    <= '0;
      fill    <= '0;
      state   <= IDLE;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_load && cfg_ok) begin
        pat   <= cfg_pattern;
        len   <= cfg_len;
        ovl   <= cfg_overlap;
        hist  <= '0;
        fill  <= '0;
        state <= FILL;
      end else if (cfg_load) begin
        state <= IDLE;
      end else begin
        state <= state_n;
        if (step) begin
          hist <= hist_n;
          fill <= fill_n;
        end
      end
    end
  assign y = state == HIT;
  seq_det_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .clr(cnt_clr),
    .q(match_cnt)
  );
endmodule

// File: tb/tb_seq_det_prog_moore.sv
// tb_seq_det_prog_moore: directed plan plus random stream against a queue-based reference model
module tb_seq_det_prog_moore;
  localparam int ML = 8, CW = 2, LW = 4;
  logic clk = 0, rst = 0, en = 0, x = 0, cfg_load = 0, cfg_overlap = 0, cnt_clr = 0;
  logic [ML-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic y, cfg_err;
  logic [CW-1:0] match_cnt;
  int checks = 0, failures = 0;
  int mlen = 0, cnt = 0;
  bit [ML-1:0] mpat;
  bit movl = 0, mvalid = 0, ey = 0, eerr = 0;
  bit q[$];
  always #5 clk = ~clk;
  seq_det_prog_moore #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .y(y), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Reference: keep the last len accepted bits; a hit is a full window equal to the pattern
  task automatic model();
    bit h = 0;
    eerr = 0;
    if (rst) begin
      mvalid = 0; mlen = 0; movl = 0; cnt = 0; q.delete();
    end else if (cfg_load) begin
      if (cfg_len >= 1 && cfg_len <= ML) begin
        mvalid = 1; mlen = int'(cfg_len); mpat = cfg_pattern; movl = cfg_overlap; q.delete();
      end else begin
        mvalid = 0; eerr = 1;
      end
    end else if (en && mvalid) begin
      q.push_back(x);
      if (q.size() > mlen) void'(q.pop_front());
      if (q.size() == mlen) begin
        h = 1;
        for (int i = 0; i < mlen; i++) if (q[mlen-1-i] != mpat[i]) h = 0;
      end
      if (h && !movl) q.delete();
    end
    ey = h;
    if (!rst) begin
      if (cnt_clr) cnt = 0;
      else if (h && cnt < (1 << CW) - 1) cnt++;
    end
  endtask
  task automatic cyc(input bit r, ld, input int cl, input bit [ML-1:0] cp, input bit co, e, xx, cc, input string tag);
    @(negedge clk);
    rst = r; cfg_load = ld; cfg_len = LW'(cl); cfg_pattern = cp; cfg_overlap = co;
    en = e; x = xx; cnt_clr = cc;
    @(posedge clk);
    model();
    #1;
    chk({tag, ".y"}, y, ey);
    chk({tag, ".cnt"}, match_cnt, cnt);
    chk({tag, ".err"}, cfg_err, eerr);
  endtask
  task automatic load(input int l, input bit [ML-1:0] p, input bit o, input string tag);
    cyc(0, 1, l, p, o, 0, 0, 0, tag);
  endtask
  task automatic send(input bit b, input string tag);
    cyc(0, 0, 0, 0, 0, 1, b, 0, tag);
  endtask
  task automatic gap(input string tag);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask
  task automatic reset_dut();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    cyc(1, 0, 0, 0, 0, 1, 1, 0, "reset");
  endtask
  initial begin
    bit [7:0] s;
    reset_dut();
    chk("reset.y_const", y, 0);
    chk("reset.cnt_const", match_cnt, 0);
    load(3, 8'b101, 1, "ovl_load");
    s = 8'b10101;
    for (int i = 4; i >= 0; i--) send(s[i], "ovl");
    chk("ovl.cnt_final", match_cnt, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, "clr");
    load(3, 8'b101, 0, "novl_load");
    s = 8'b10101101;
    for (int i = 7; i >= 0; i--) send(s[i], "novl");
    chk("novl.cnt_final", match_cnt, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, "clr");
    load(8, 8'hA5, 0, "gap_load");
    s = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      send(s[i], "gap");
      if (i == 4) begin gap("gap_idle"); gap("gap_idle"); end
    end
    gap("gap_after");
    load(0, 8'h1, 0, "err0");
    gap("err0_after");
    load(ML + 1, 8'h1, 0, "err9");
    for (int i = 0; i < 6; i++) send(1'b1, "idle_stream");
    chk("idle.y_const", y, 0);
    load(1, 8'h1, 0, "len1_load");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, "clr");
    for (int i = 0; i < 4; i++) send(1'b1, "len1");
    chk("len1.sat_const", match_cnt, 3);
    cyc(0, 0, 0, 0, 0, 1, 1, 1, "len1_clr");
    chk("len1_clr.y_const", y, 1);
    load(3, 8'b101, 1, "rst_load");
    send(1, "rst_pre"); send(0, "rst_pre");
    reset_dut();
    load(3, 8'b101, 1, "rst_reload");
    send(1, "rst_post");
    s = 8'b101;
    for (int i = 2; i >= 0; i--) send(s[i], "rst_full");
    chk("rst_full.y_const", y, 1);
    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 1) reset_dut();
      else if (r < 4) load($urandom_range(0, 10), ML'($urandom), $urandom_range(0, 1), "rnd_load");
      else cyc(0, 0, 0, 0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 19) == 0, "rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
